noc_client_inject: RTL and testbench
====================================

Name: noc_client_inject

Overview:
- Client-side injection stage that feeds one credit-based input port of a t-switch, such as the left or right leaf input.
- Accepts flits from a client over a per-VC data/valid/backpressure (DVR) interface and buffers each VC in a 2-entry skid buffer.
- Arbitrates round-robin among VCs that hold both a flit and a credit, then drives one registered flit per cycle onto the link.
- Tracks downstream receiver FIFO space with per-VC credit counters, replenished by credit-return pulses from the switch.

Parameters:
- N, DEFAULT_N: number of clients; used only for the address range check.
- A_W, DEFAULT_A_W: address width.
- D_W, DEFAULT_D_W: payload width.
- VC_W, DEFAULT_VC_W: number of virtual channels.
- VC_FIFO_DEPTH, DEFAULT_VC_FIFO_DEPTH: receiver FIFO depth parameter. Usable receiver slots, and therefore initial credits, are VC_FIFO_DEPTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_v  in  VC_W  client flit valid, per VC
- i_d  in  VC_W x (A_W+D_W+1)  client flit, per VC; format {dest[A_W-1:0], payload[D_W-1:0], eop}
- o_b  out  VC_W  backpressure to client, per VC
- tx_v  out  VC_W  link flit valid, one-hot or zero
- tx_d  out  A_W+D_W+1  link flit
- tx_credit  in  VC_W  credit-return pulses from receiver, one credit per bit per cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_v=0, tx_d=0.
  - All skid buffers empty; o_b=0.
  - Credit counters = VC_FIFO_DEPTH-1.
  - Round-robin pointer = VC0.
  - Release is synchronous to clk. No output glitches or credit changes occur during reset.
  - Reset mid-operation discards buffered flits and restores full credits; in-flight credit returns are ignored.
- Client handshake:
  - A flit is accepted on VCk when i_v[k]=1 and o_b[k]=0 at the clock edge.
  - o_b[k] is registered: o_b[k]=1 exactly when VCk's skid buffer holds 2 entries after the edge.
  - Accept and drain in the same cycle is allowed; occupancy is unchanged.
  - i_d is held undefined-safe when i_v=0.
- Eligibility: VCk is eligible when its skid buffer is not empty and credit[k]>0.
- Arbitration:
  - Round-robin over eligible VCs, searching from (last_grant+1) mod VC_W.
  - At most one grant per cycle.
  - The pointer advances only on a grant.
- Output register:
  - On grant of VCk, tx_v is one-hot with bit k set and tx_d = head of VCk, both registered.
  - The head is popped and credit[k] decrements in the same cycle.
  - With no grant, tx_v=0 and tx_d holds its last value.
  - There is no downstream stall signal; credits alone guarantee space.
- Latency: a flit accepted at edge t into an empty VC with credit and no competing VC appears on tx at edge t+1. Minimum latency is 1 cycle.
- Credit arithmetic:
  - Counter width is $clog2(VC_FIFO_DEPTH)+1.
  - Next value = credit + tx_credit[k] - grant[k]. Simultaneous return and send on the same VC leaves the count unchanged.
  - credit=0 makes the VC ineligible until a return arrives. The flit stays buffered and is never dropped.
  - A return that would exceed VC_FIFO_DEPTH-1 is a protocol error: the counter saturates at VC_FIFO_DEPTH-1, and a SIMULATION assertion fires.
- eop is carried transparently.
  - VCs are interleaved at flit granularity; no packet lock is applied.
- Address check: a SIMULATION assertion fires if a flit is accepted with dest >= N.
- Throughput: with credits available on every VC, sustained rate is 1 flit per cycle aggregate. Each VC sustains 1 flit per cycle when it is the only one active.

Optional Feature:
- Macro: NOC_CLIENT_INJECT_STATS_EN.
- Defined:
  - Extra ports stat_flits (out, 32) and stat_credit_stalls (out, 32), both reset to 0.
  - stat_flits increments on every grant.
  - stat_credit_stalls increments each cycle in which any VC has a non-empty buffer and credit=0.
  - Both counters wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold rst=0 with random inputs → tx_v=0, o_b=0, tx_d=0. After release, VC_W=2 and VC_FIFO_DEPTH=4 give credits 3/3.
- Single flit: VC0, i_d={dest=3, payload=0xA5, eop=1} accepted at edge t → tx_v=2'b01 with the same tx_d at t+1; credit0 becomes 2.
- Credit exhaustion: with DEPTH=4, stream 5 flits on VC1 with no returns → 3 flits sent, then tx_v=0, o_b[1]=1 once 2 flits are buffered. A tx_credit[1] pulse releases exactly 1 flit, on the next edge.
- Simultaneous return and send: credit0=1; grant VC0 while tx_credit[0]=1 in the same cycle → credit0 stays 1 and the next flit issues the following cycle.
- Round-robin: VC0 and VC1 continuously valid with ample credits → tx_v alternates 01,10,01,10… with no gaps.
- Reset mid-stream: assert rst while both buffers are full and credit0=0 → buffers flushed, credits back to 3, no flit emitted. With NOC_CLIENT_INJECT_STATS_EN defined, stat_flits=0 after reset.

Source files
------------

// File: rtl/noc_client_inject.sv
// Client injection stage: per-VC 2-entry skid buffers, round-robin arbitration over
// VCs holding a flit and a credit, registered link output. Optional counters: NOC_CLIENT_INJECT_STATS_EN.
module noc_client_inject #(
    parameter int N             = 4,
    parameter int A_W           = 2,
    parameter int D_W           = 8,
    parameter int VC_W          = 2,
    parameter int VC_FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [VC_W-1:0]                i_v,
    input  logic [VC_W*(A_W+D_W+1)-1:0]    i_d,
    output logic [VC_W-1:0]                o_b,
    output logic [VC_W-1:0]                tx_v,
    output logic [A_W+D_W:0]               tx_d,
    input  logic [VC_W-1:0]                tx_credit
`ifdef NOC_CLIENT_INJECT_STATS_EN
    ,
    output logic [31:0]                    stat_flits,
    output logic [31:0]                    stat_credit_stalls
`endif
);

    localparam int FW = A_W + D_W + 1;
    localparam int CW = $clog2(VC_FIFO_DEPTH) + 1;
    localparam int PW = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(VC_FIFO_DEPTH - 1);

    logic [FW-1:0]   buf0     [VC_W];
    logic [FW-1:0]   buf1     [VC_W];
    logic [1:0]      occ      [VC_W];
    logic [1:0]      occ_nxt  [VC_W];
    logic [CW-1:0]   credit   [VC_W];
    logic [CW-1:0]   cred_sum [VC_W];
    logic [CW-1:0]   cred_nxt [VC_W];
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   scan;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [VC_W-1:0] elig;
    logic [VC_W-1:0] grant;
    logic [VC_W-1:0] accept;

    always_comb begin
        for (int unsigned i = 0; i < VC_W; i++) begin
            elig[i]   = (occ[i] != 2'd0) && (credit[i] != '0);
            accept[i] = i_v[i] & ~o_b[i];
        end
    end

    // First eligible VC at or after rr_ptr wins; rr_ptr always holds last_grant+1.
    always_comb begin
        grant     = '0;
        grant_idx = rr_ptr;
        grant_any = 1'b0;
        scan      = rr_ptr;
        for (int unsigned i = 0; i < VC_W; i++) begin
            scan = PW'((32'(rr_ptr) + i) % VC_W);
            if (!grant_any && elig[scan]) begin
                grant_any = 1'b1;
                grant_idx = scan;
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_comb begin
        for (int unsigned i = 0; i < VC_W; i++) begin
            occ_nxt[i]  = occ[i] + {1'b0, accept[i]} - {1'b0, grant[i]};
            cred_sum[i] = credit[i] + CW'(tx_credit[i]) - CW'(grant[i]);
            cred_nxt[i] = (cred_sum[i] > CRED_MAX) ? CRED_MAX : cred_sum[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < VC_W; i++) begin
                buf0[i]   <= '0;
                buf1[i]   <= '0;
                occ[i]    <= 2'd0;
                credit[i] <= CRED_MAX;
            end
            o_b    <= '0;
            tx_v   <= '0;
            tx_d   <= '0;
            rr_ptr <= '0;
        end else begin
            tx_v <= grant;
            if (grant_any) begin
                tx_d   <= buf0[grant_idx];
                rr_ptr <= PW'((32'(grant_idx) + 1) % VC_W);
            end
            for (int unsigned i = 0; i < VC_W; i++) begin
                // buf0 is always the head; a pop shifts buf1 forward
                case ({accept[i], grant[i]})
                    2'b10: begin
                        if (occ[i] == 2'd0) buf0[i] <= i_d[i*FW +: FW];
                        else                buf1[i] <= i_d[i*FW +: FW];
                    end
                    2'b01: buf0[i] <= buf1[i];
                    2'b11: begin
                        if (occ[i] == 2'd1) begin
                            buf0[i] <= i_d[i*FW +: FW];
                        end else begin
                            buf0[i] <= buf1[i];
                            buf1[i] <= i_d[i*FW +: FW];
                        end
                    end
                    default: ;
                endcase
                occ[i]    <= occ_nxt[i];
                credit[i] <= cred_nxt[i];
                o_b[i]    <= (occ_nxt[i] == 2'd2);
            end
        end
    end

`ifdef NOC_CLIENT_INJECT_STATS_EN
    logic stall_any;

    always_comb begin
        stall_any = 1'b0;
        for (int unsigned i = 0; i < VC_W; i++)
            if (occ[i] != 2'd0 && credit[i] == '0) stall_any = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_flits         <= '0;
            stat_credit_stalls <= '0;
        end else begin
            if (grant_any) stat_flits         <= stat_flits + 32'd1;
            if (stall_any) stat_credit_stalls <= stat_credit_stalls + 32'd1;
        end
    end
`endif

    for (genvar k = 0; k < VC_W; k++) begin : g_chk
        a_credit_ovf: assert property (@(posedge clk) disable iff (!rst)
            !(tx_credit[k] && !grant[k] && credit[k] == CRED_MAX));
        a_dest_range: assert property (@(posedge clk) disable iff (!rst)
            !(accept[k] && 32'(i_d[k*FW + FW - 1 -: A_W]) >= N));
    end

endmodule

// File: tb/tb_noc_client_inject.sv
// Scoreboard bench for noc_client_inject: queue-based reference model, random and directed traffic.
module tb_noc_client_inject;

    localparam int N     = 4;
    localparam int A_W   = 2;
    localparam int D_W   = 8;
    localparam int VC_W  = 2;
    localparam int DEPTH = 4;
    localparam int FW    = A_W + D_W + 1;
    localparam int CMAX  = DEPTH - 1;

    typedef struct {
        int unsigned cyc;
        int          vc;
        logic [FW-1:0] d;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [VC_W-1:0]      i_v = '0;
    logic [VC_W*FW-1:0]   i_d = '0;
    logic [VC_W-1:0]      o_b;
    logic [VC_W-1:0]      tx_v;
    logic [FW-1:0]        tx_d;
    logic [VC_W-1:0]      tx_credit = '0;
`ifdef NOC_CLIENT_INJECT_STATS_EN
    logic [31:0]          stat_flits;
    logic [31:0]          stat_credit_stalls;
    int unsigned          mflits, mstalls;
`endif

    noc_client_inject #(
        .N(N), .A_W(A_W), .D_W(D_W), .VC_W(VC_W), .VC_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .i_v(i_v), .i_d(i_d), .o_b(o_b),
        .tx_v(tx_v), .tx_d(tx_d), .tx_credit(tx_credit)
`ifdef NOC_CLIENT_INJECT_STATS_EN
        , .stat_flits(stat_flits), .stat_credit_stalls(stat_credit_stalls)
`endif
    );

    always #5 clk = ~clk;

    // stimulus sources, reference model state, scoreboard
    logic [FW-1:0]   src [VC_W][$];
    logic [FW-1:0]   mq  [VC_W][$];
    int              mcred [VC_W];
    int              rr;
    logic [VC_W-1:0] m_ob;
    exp_t            exp_q[$];
    int unsigned     cyc = 0;

    int              vrate = 100, rrate = 0, rmode = 0;
    logic [VC_W-1:0] man_ret = '0;

    int              checks = 0, failures = 0;
    int              sent_cnt [VC_W];
    int unsigned     last_cyc [VC_W];
    int unsigned     prev_cyc [VC_W];
    int              log_vc[$];
    int unsigned     log_cyc[$];

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic logic [FW-1:0] rand_flit();
        logic [A_W-1:0] dst;
        logic [D_W-1:0] pay;
        logic           eop;
        dst = A_W'($urandom_range(0, N-1));
        pay = D_W'($urandom);
        eop = 1'($urandom);
        return {dst, pay, eop};
    endfunction

    initial for (int k = 0; k < VC_W; k++) begin
        sent_cnt[k] = 0; last_cyc[k] = 0; prev_cyc[k] = 0; mcred[k] = CMAX;
    end

    // Driver: inputs change on the falling edge only
    always @(negedge clk) begin
        for (int k = 0; k < VC_W; k++) begin
            if (!rst) begin
                i_v[k]            = 1'($urandom);
                tx_credit[k]      = 1'($urandom);
                i_d[k*FW +: FW]   = FW'($urandom);
            end else begin
                i_v[k]            = (src[k].size() > 0) && ($urandom_range(0, 99) < vrate);
                i_d[k*FW +: FW]   = i_v[k] ? src[k][0] : FW'($urandom);
                tx_credit[k]      = (mcred[k] < CMAX) &&
                                    ((rmode != 0 && $urandom_range(0, 99) < rrate) || man_ret[k]);
            end
        end
        man_ret = '0;
    end

    // Reference model: evaluated from the values present at each rising edge
    always @(posedge clk) begin
        int g;
        cyc++;
        if (!rst) begin
            for (int k = 0; k < VC_W; k++) begin
                mq[k].delete();
                mcred[k] = CMAX;
            end
            rr = 0;
            m_ob = '0;
            exp_q.delete();
`ifdef NOC_CLIENT_INJECT_STATS_EN
            mflits = 0; mstalls = 0;
`endif
        end else begin
`ifdef NOC_CLIENT_INJECT_STATS_EN
            begin
                bit st;
                st = 0;
                for (int k = 0; k < VC_W; k++)
                    if (mq[k].size() > 0 && mcred[k] == 0) st = 1;
                if (st) mstalls++;
            end
`endif
            g = -1;
            for (int i = 0; i < VC_W; i++)
                if (g < 0 && mq[(rr + i) % VC_W].size() > 0 && mcred[(rr + i) % VC_W] > 0)
                    g = (rr + i) % VC_W;
            if (g >= 0) begin
                exp_q.push_back('{cyc: cyc, vc: g, d: mq[g].pop_front()});
                rr = (g + 1) % VC_W;
`ifdef NOC_CLIENT_INJECT_STATS_EN
                mflits++;
`endif
            end
            for (int k = 0; k < VC_W; k++) begin
                mcred[k] = mcred[k] + int'(tx_credit[k]) - ((g == k) ? 1 : 0);
                if (mcred[k] > CMAX) mcred[k] = CMAX;
                if (i_v[k] && !m_ob[k]) begin
                    mq[k].push_back(i_d[k*FW +: FW]);
                    void'(src[k].pop_front());
                end
                m_ob[k] = (mq[k].size() == 2);
            end
        end
    end

    // Monitor: samples 1 time unit after the rising edge
    always @(posedge clk) begin
        exp_t e;
        bit due;
        logic [VC_W-1:0] oh;
        #1;
        if (!rst) begin
            chk(tx_v == '0 && o_b == '0 && tx_d == '0, "reset_outputs", {tx_v, o_b, tx_d}, 0);
        end else begin
            chk(o_b == m_ob, "o_b", o_b, m_ob);
            due = exp_q.size() > 0 && exp_q[0].cyc <= cyc;
            chk((tx_v != '0) == due, "tx_presence", tx_v, due);
            for (int k = 0; k < VC_W; k++)
                if (tx_v[k]) begin
                    sent_cnt[k]++;
                    prev_cyc[k] = last_cyc[k];
                    last_cyc[k] = cyc;
                    log_vc.push_back(k);
                    log_cyc.push_back(cyc);
                end
            if ((tx_v != '0 || due) && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e.vc] = 1'b1;
                chk(cyc == e.cyc, "tx_cycle", cyc, e.cyc);
                chk(tx_v == oh, "tx_v", tx_v, oh);
                chk(tx_d == e.d, "tx_d", tx_d, e.d);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_quiet(input int budget, input bit full);
        bit done;
        done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = 1;
            for (int k = 0; k < VC_W; k++)
                if (src[k].size() != 0 || mq[k].size() != 0 || (full && mcred[k] != CMAX))
                    done = 0;
            if (exp_q.size() != 0) done = 0;
        end
        chk(done, "quiet_timeout", done, 1);
    endtask

    initial begin
        int base0, base1;
        bit ok;
        logic [FW-1:0] f;

        // reset held with random inputs
        step(4);
        rst = 1'b1;
        step(2);

        // single flit, 1-cycle latency, tx_d holds afterwards
        f = {2'd3, 8'hA5, 1'b1};
        src[0].push_back(f);
        wait_quiet(20, 0);
        chk(sent_cnt[0] == 1, "single_count", sent_cnt[0], 1);
        chk(tx_d == f, "tx_d_hold", tx_d, f);

        // credit exhaustion on VC1
        base1 = sent_cnt[1];
        for (int i = 0; i < 5; i++) src[1].push_back(rand_flit());
        step(12);
        chk(sent_cnt[1] - base1 == 3, "exhaust_sent", sent_cnt[1] - base1, 3);
        chk(o_b[1] == 1'b1, "exhaust_ob", o_b[1], 1);
        man_ret[1] = 1'b1;
        step(5);
        chk(sent_cnt[1] - base1 == 4, "single_return_release", sent_cnt[1] - base1, 4);
        rmode = 1; rrate = 100;
        wait_quiet(60, 1);

        // round-robin with ample credits
        log_vc.delete(); log_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            src[0].push_back(rand_flit());
            src[1].push_back(rand_flit());
        end
        wait_quiet(80, 1);
        ok = (log_vc.size() == 16);
        for (int i = 1; i < log_vc.size(); i++)
            if (log_vc[i] == log_vc[i-1] || log_cyc[i] != log_cyc[i-1] + 1) ok = 0;
        chk(ok, "rr_alternate_no_gap", log_vc.size(), 16);

        // return and send on VC0 in the same cycle with credit0=1
        rmode = 0;
        src[0].push_back(rand_flit());
        src[0].push_back(rand_flit());
        wait_quiet(20, 0);
        base0 = sent_cnt[0];
        src[0].push_back(rand_flit());
        src[0].push_back(rand_flit());
        for (int c = 0; c < 10 && src[0].size() != 1; c++) step();
        man_ret[0] = 1'b1;
        step(4);
        chk(sent_cnt[0] - base0 == 2, "ret_send_count", sent_cnt[0] - base0, 2);
        chk(last_cyc[0] - prev_cyc[0] == 1, "ret_send_back2back", last_cyc[0] - prev_cyc[0], 1);

        // reset mid-stream with both buffers full and credit0=0
        for (int i = 0; i < 2; i++) src[0].push_back(rand_flit());
        for (int i = 0; i < 5; i++) src[1].push_back(rand_flit());
        step(12);
        chk(o_b == 2'b11, "both_full", o_b, 2'b11);
        base0 = sent_cnt[0];
        base1 = sent_cnt[1];
        rst = 1'b0;
        for (int k = 0; k < VC_W; k++) src[k].delete();
        #1;
        chk(tx_v == '0 && o_b == '0 && tx_d == '0, "async_reset", {tx_v, o_b, tx_d}, 0);
`ifdef NOC_CLIENT_INJECT_STATS_EN
        chk(stat_flits == 0, "stat_flits_reset", stat_flits, 0);
`endif
        step(3);
        chk(sent_cnt[0] == base0 && sent_cnt[1] == base1, "no_tx_in_reset",
            sent_cnt[0] + sent_cnt[1], base0 + base1);
        rst = 1'b1;
        step();
        base0 = sent_cnt[0];
        for (int i = 0; i < 4; i++) src[0].push_back(rand_flit());
        step(15);
        chk(sent_cnt[0] - base0 == 3, "credits_restored", sent_cnt[0] - base0, 3);

        // random traffic with random returns
        rmode = 1; rrate = 40; vrate = 70;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < VC_W; k++)
                if (src[k].size() < 3 && $urandom_range(0, 1) == 1) src[k].push_back(rand_flit());
            step();
        end
        vrate = 100; rrate = 100;
        wait_quiet(200, 1);
`ifdef NOC_CLIENT_INJECT_STATS_EN
        chk(stat_flits == mflits, "stat_flits", stat_flits, mflits);
        chk(stat_credit_stalls == mstalls, "stat_credit_stalls", stat_credit_stalls, mstalls);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=%0d expected=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
